// File: rtl/wb_pkg.sv
// Shared encodings for the register-bank write-back sequencer.
// Holds state encoding, mux codes and the stack-pointer init constant.
package wb_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_SP_WR = 3'd1,
    ST_IDLE  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4
  } wb_state_e;

  typedef logic [2:0] wb_src_t;
  typedef logic [1:0] wb_dst_t;

  // Write-data mux sources; code 7 routes the hard-wired $sp init constant.
  localparam wb_src_t WB_SRC_ALU   = 3'd0;
  localparam wb_src_t WB_SRC_MEM   = 3'd1;
  localparam wb_src_t WB_SRC_HI    = 3'd2;
  localparam wb_src_t WB_SRC_LO    = 3'd3;
  localparam wb_src_t WB_SRC_PC4   = 3'd4;
  localparam wb_src_t WB_SRC_IMM   = 3'd5;
  localparam wb_src_t WB_SRC_SHIFT = 3'd6;
  localparam wb_src_t WB_SRC_CONST = 3'd7;

  localparam wb_dst_t WB_DST_RT = 2'd0;
  localparam wb_dst_t WB_DST_RD = 2'd1;
  localparam wb_dst_t WB_DST_RA = 2'd2;
  localparam wb_dst_t WB_DST_SP = 2'd3;

  localparam logic [31:0] SP_INIT_VALUE = 32'd227;

  localparam int WAIT_MAX_DEFAULT = 40;
  localparam int CNT_W_DEFAULT    = 6;

endpackage

// File: rtl/wb_ctrl_if.sv
// Request/response bundle between the main control unit and the write-back sequencer.
interface wb_ctrl_if;
  import wb_pkg::*;

  logic    start;
  wb_src_t wb_src;
  wb_dst_t wb_dst;
  logic    src_wait;
  logic    abort;
  wb_src_t mux_wd_sel;
  wb_dst_t mux_wr_sel;
  logic    reg_write;
  logic    busy;
  logic    done;
  logic    timeout;
  logic    init_done;

  modport master (
    output start, wb_src, wb_dst, src_wait, abort,
    input  mux_wd_sel, mux_wr_sel, reg_write, busy, done, timeout, init_done
  );

  modport slave (
    input  start, wb_src, wb_dst, src_wait, abort,
    output mux_wd_sel, mux_wr_sel, reg_write, busy, done, timeout, init_done
  );

endinterface

// File: rtl/wb_wait_timer.sv
// Stall counter for a pending write-back: clear, count-enable and terminal-count flag.
module wb_wait_timer #(
  parameter int WAIT_MAX = 40,
  parameter int CNT_W    = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  // tc_o flags the last permitted stall cycle, so WAIT_MAX stall cycles end the request.
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(WAIT_MAX - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == TC_VAL);

endmodule

// File: rtl/wb_ctrl.sv
// Write-back sequencer: one-time $sp init write, then latched write-back requests
// with source stall handling, abort and stall timeout. All outputs are registered.
module wb_ctrl
  import wb_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEFAULT,
  parameter int CNT_W    = CNT_W_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  wb_ctrl_if.slave   bus
);

  wb_state_e  state_q;
  wb_src_t    mux_wd_sel_q;
  wb_dst_t    mux_wr_sel_q;
  logic       reg_write_q;
  logic       busy_q;
  logic       done_q;
  logic       timeout_q;
  logic       init_done_q;

  logic             accept;
  logic             tmr_clr;
  logic             tmr_en;
  logic             tmr_tc;
  logic [CNT_W-1:0] tmr_cnt;

  // abort beats start in IDLE, so an aborted cycle never opens a request.
  assign accept  = (state_q == ST_IDLE) && bus.start && !bus.abort;
  assign tmr_clr = accept;
  assign tmr_en  = (state_q == ST_WAIT) && bus.src_wait && !bus.abort;

  wb_wait_timer #(
    .WAIT_MAX (WAIT_MAX),
    .CNT_W    (CNT_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .cnt_o (tmr_cnt),
    .tc_o  (tmr_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_INIT;
      mux_wd_sel_q <= '0;
      mux_wr_sel_q <= '0;
      reg_write_q  <= 1'b0;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        ST_INIT: begin
          state_q      <= ST_SP_WR;
          mux_wd_sel_q <= WB_SRC_CONST;
          mux_wr_sel_q <= WB_DST_SP;
          reg_write_q  <= 1'b1;
          busy_q       <= 1'b1;
        end
        ST_SP_WR: begin
          state_q      <= ST_IDLE;
          mux_wd_sel_q <= '0;
          mux_wr_sel_q <= '0;
          reg_write_q  <= 1'b0;
          busy_q       <= 1'b0;
          init_done_q  <= 1'b1;
        end
        ST_IDLE: begin
          if (accept) begin
            // The selector registers double as the request latch.
            state_q      <= ST_WAIT;
            mux_wd_sel_q <= bus.wb_src;
            mux_wr_sel_q <= bus.wb_dst;
            busy_q       <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (bus.abort) begin
            state_q      <= ST_IDLE;
            mux_wd_sel_q <= '0;
            mux_wr_sel_q <= '0;
            busy_q       <= 1'b0;
          end else if (!bus.src_wait) begin
            state_q     <= ST_WRITE;
            reg_write_q <= 1'b1;
            done_q      <= 1'b1;
          end else if (tmr_tc) begin
            state_q      <= ST_IDLE;
            mux_wd_sel_q <= '0;
            mux_wr_sel_q <= '0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b1;
          end
        end
        ST_WRITE: begin
          state_q      <= ST_IDLE;
          mux_wd_sel_q <= '0;
          mux_wr_sel_q <= '0;
          reg_write_q  <= 1'b0;
          busy_q       <= 1'b0;
        end
        default: begin
          state_q      <= ST_INIT;
          mux_wd_sel_q <= '0;
          mux_wr_sel_q <= '0;
          reg_write_q  <= 1'b0;
          busy_q       <= 1'b1;
        end
      endcase
    end
  end

  assign bus.mux_wd_sel = mux_wd_sel_q;
  assign bus.mux_wr_sel = mux_wr_sel_q;
  assign bus.reg_write  = reg_write_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.timeout    = timeout_q;
  assign bus.init_done  = init_done_q;

  logic unused_cnt;
  assign unused_cnt = ^tmr_cnt;

endmodule
